// File: rtl/agex_muldiv_unit.sv
// agex_muldiv_unit: iterative RV32M multiply/divide unit beside the AGEX ALU.
// Multiply uses shift-add into a 2*XLEN product; divide uses restoring division.
// Both work on operand magnitudes; the sign is applied when entering DONE.
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  request handshake (ready only while IDLE)
//   op_i, rs1_i, rs2_i       funct3 and operands, sampled only on the accept edge
//   tag_i / tag_o            destination tag, captured on accept
//   flush_i                  kills any operation in flight, wins over every handshake
//   out_valid_o / out_ready_i result handshake; result_o and tag_o held while waiting
//   busy_o                   high whenever the unit is not IDLE
module agex_muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned NSTEPS = XLEN / STEP_BITS;
  localparam int unsigned CNT_W  = $clog2(NSTEPS) + 1;
  localparam int unsigned PW     = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic              neg_main_q, neg_main_d;
  logic              neg_rem_q, neg_rem_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   result_d;
  logic [TAG_W-1:0]  tag_d;

  logic              rs1_signed, rs2_signed;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;

  logic [PW-1:0]     prod_s;
  logic [XLEN-1:0]   rem_s, quo_s;
  logic [XLEN:0]     rem_t, sum_t;
  logic [PW-1:0]     prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin;
  logic [XLEN-1:0]   calc_result;

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);

  // Signedness of the incoming operands, decoded from funct3
  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (op_i)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      OP_MULHSU: rs1_signed = 1'b1;
      default: ;
    endcase
  end

  assign rs1_neg = rs1_signed & rs1_i[XLEN-1];
  assign rs2_neg = rs2_signed & rs2_i[XLEN-1];
  assign rs1_mag = rs1_neg ? -rs1_i : rs1_i;
  assign rs2_mag = rs2_neg ? -rs2_i : rs2_i;

  // One CALC cycle: retire STEP_BITS multiplier bits or quotient bits
  always_comb begin
    prod_s = prod_q;
    rem_s  = rem_q;
    quo_s  = quo_q;
    rem_t  = '0;
    sum_t  = '0;
    for (int unsigned i = 0; i < STEP_BITS; i++) begin
      if (op_q[2]) begin
        // rem_t is one bit wider so the shifted partial remainder never overflows
        rem_t = {rem_s, quo_s[XLEN-1]};
        quo_s = {quo_s[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, b_mag_q}) begin
          rem_t    = rem_t - {1'b0, b_mag_q};
          quo_s[0] = 1'b1;
        end
        rem_s = rem_t[XLEN-1:0];
      end else begin
        // multiplier sits in the low half and is consumed LSB first
        sum_t  = {1'b0, prod_s[PW-1:XLEN]} + (prod_s[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
        prod_s = {sum_t, prod_s[XLEN-1:1]};
      end
    end
  end

  // Sign application and result select for the final CALC cycle
  always_comb begin
    prod_fin = neg_main_q ? -prod_s : prod_s;
    quo_fin  = neg_main_q ? -quo_s : quo_s;
    rem_fin  = neg_rem_q ? -rem_s : rem_s;
    if (op_q[2]) begin
      calc_result = op_q[1] ? rem_fin : quo_fin;
    end else if (op_q[1:0] == 2'b00) begin
      calc_result = prod_fin[XLEN-1:0];
    end else begin
      calc_result = prod_fin[PW-1:XLEN];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_o;
    tag_d      = tag_o;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i && !flush_i) begin
          op_d       = op_i;
          tag_d      = tag_i;
          a_mag_d    = rs1_mag;
          b_mag_d    = rs2_mag;
          neg_main_d = rs1_neg ^ rs2_neg;
          neg_rem_d  = rs1_neg;
          prod_d     = {{XLEN{1'b0}}, rs2_mag};
          rem_d      = '0;
          quo_d      = rs1_mag;
          cnt_d      = CNT_W'(NSTEPS - 1);
          if (op_i[2] && (rs2_i == '0)) begin
            // divide by zero: quotient all ones, remainder is the raw dividend
            state_d  = DONE;
            result_d = op_i[1] ? rs1_i : '1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prod_d = prod_s;
        rem_d  = rem_s;
        quo_d  = quo_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d    = '0;
          state_d  = DONE;
          result_d = calc_result;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_o   <= '0;
      tag_o      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_o   <= result_d;
      tag_o      <= tag_d;
    end
  end

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// tb_agex_muldiv_unit: two instances (STEP_BITS 1 and 4) share one stimulus stream.
// A latency/result model per instance is compared against the outputs every cycle.
module tb_agex_muldiv_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int N_RAND = 1200;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  rs1 = '0;
  logic [XLEN-1:0]  rs2 = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;

  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       busy;
  logic [XLEN-1:0]  result [2];
  logic [TAG_W-1:0] tag_out [2];

  int checks = 0;
  int errors = 0;

  bit               m_pend [2];
  int               m_left [2];
  logic [XLEN-1:0]  m_res [2];
  logic [TAG_W-1:0] m_tag [2];
  logic [XLEN-1:0]  cap_res [2];
  int               lat [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    agex_muldiv_unit #(
      .XLEN(XLEN), .TAG_W(TAG_W), .STEP_BITS((g == 0) ? 1 : 4)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid_i(in_valid), .in_ready_o(in_ready[g]),
      .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag),
      .flush_i(flush),
      .out_valid_o(out_valid[g]), .out_ready_i(out_ready),
      .result_o(result[g]), .tag_o(tag_out[g]), .busy_o(busy[g])
    );
  end

  function automatic int steps_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // RV32M reference result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    r  = '0;
    case (f)
      3'd0: r = a * b;
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input int i, input logic [2:0] f, input logic [31:0] b);
    return (f[2] && b == 0) ? 1 : 32 / steps_of(i) + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Behavioural model: countdown to the valid cycle, then wait for the handshake
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || flush) begin
        m_pend[i] <= 1'b0;
      end else if (m_pend[i]) begin
        if (m_left[i] > 0) m_left[i] <= m_left[i] - 1;
        else if (out_ready) m_pend[i] <= 1'b0;
      end else if (in_valid) begin
        m_pend[i] <= 1'b1;
        m_res[i]  <= ref_result(op, rs1, rs2);
        m_tag[i]  <= tag;
        m_left[i] <= exp_lat(i, op, rs2) - 1;
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit ev;
        ev = !reset && m_pend[i] && (m_left[i] == 0);
        chk("out_valid", i, 32'(out_valid[i]), 32'(ev));
        chk("in_ready", i, 32'(in_ready[i]), 32'(!m_pend[i]));
        chk("busy", i, 32'(busy[i]), 32'(m_pend[i]));
        if (ev) begin
          chk("result", i, result[i], m_res[i]);
          chk("tag", i, 32'(tag_out[i]), 32'(m_tag[i]));
          cap_res[i] = result[i];
        end
        if (reset) begin
          chk("reset_result", i, result[i], 32'd0);
          chk("reset_tag", i, 32'(tag_out[i]), 32'd0);
        end
      end
    end
  endtask

  task automatic junk();
    op  = 3'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
    tag = TAG_W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_pend[0] || m_pend[1] || busy != 2'b00) && n < budget) begin
      @(negedge clk);
      junk();
      n++;
    end
    chk("settle", 0, 32'({m_pend[0], m_pend[1], busy}), 32'd0);
  endtask

  task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    op = f; rs1 = a; rs2 = b; tag = t;
  endtask

  task automatic run_op(input string name, input vec_t v, input logic [TAG_W-1:0] t);
    bit seen [2];
    int c;
    out_ready = 1'b1;
    seen = '{1'b0, 1'b0};
    lat = '{0, 0};
    drive_req(v.f, v.a, v.b, t);
    c = 0;
    while (!(seen[0] && seen[1]) && c < 100) begin
      @(negedge clk);
      c++;
      if (c == 1) begin in_valid = 1'b0; junk(); end
      for (int i = 0; i < 2; i++) begin
        if (!seen[i] && out_valid[i]) begin seen[i] = 1'b1; lat[i] = c; end
      end
    end
    in_valid = 1'b0;
    wait_idle(20);
    chk({name, " model"}, 0, ref_result(v.f, v.a, v.b), v.r);
    for (int i = 0; i < 2; i++) begin
      chk({name, " latency"}, i, 32'(lat[i]), 32'(exp_lat(i, v.f, v.b)));
      chk({name, " value"}, i, cap_res[i], v.r);
    end
  endtask

  initial begin
    vec_t vecs [14];
    int   cnt;
    vecs = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,         32'd14},
      '{3'd7, 32'd100,        32'd7,         32'd2},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd6, 32'd5,          32'd0,         32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd5, 32'd0,          32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd9,          32'd0,         32'd9}
    };

    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    for (int k = 0; k < 14; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k], TAG_W'(k + 1));
    end

    // Stall in DONE: result and tag must hold while out_ready is low
    out_ready = 1'b0;
    drive_req(3'd0, 32'd123, 32'd456, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid != 2'b11 && cnt < 100) begin @(negedge clk); junk(); cnt++; end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("stall valid", i, 32'(out_valid[i]), 32'd1);
      chk("stall result", i, result[i], 32'd56088);
      chk("stall tag", i, 32'(tag_out[i]), 32'd9);
    end
    out_ready = 1'b1;
    wait_idle(20);

    // Flush in CALC cycle 5: idle on the next cycle and no result afterwards
    drive_req(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush valid", i, 32'(out_valid[i]), 32'd0);
      chk("flush ready", i, 32'(in_ready[i]), 32'd1);
      chk("flush busy", i, 32'(busy[i]), 32'd0);
    end
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of CALC
    drive_req(3'd5, 32'd1000, 32'd3, 5'd17);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst valid", i, 32'(out_valid[i]), 32'd0);
      chk("arst ready", i, 32'(in_ready[i]), 32'd1);
      chk("arst busy", i, 32'(busy[i]), 32'd0);
      chk("arst result", i, result[i], 32'd0);
      chk("arst tag", i, 32'(tag_out[i]), 32'd0);
    end
    @(negedge clk);
    #2 reset = 1'b0;

    // Randomised traffic with backpressure and occasional flushes
    for (int n = 0; n < N_RAND; n++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      op        = 3'($urandom);
      rs1       = pick();
      rs2       = pick();
      tag       = TAG_W'($urandom);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      cnt = 0;
      while ((m_pend[0] || m_pend[1] || busy != 2'b00) && cnt < 500) begin
        junk();
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 79) == 0);
        @(negedge clk);
        cnt++;
      end
      flush = 1'b0;
      chk("rand settle", 0, 32'({m_pend[0], m_pend[1], busy}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
